// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory responder: I/O page offsets, timer
// control/status bit positions and register reset values.
package mmio_pkg;

    localparam logic [5:0] LED_OFS    = 6'h00;
    localparam logic [5:0] SW_OFS     = 6'h04;
    localparam logic [5:0] TCTRL_OFS  = 6'h08;
    localparam logic [5:0] TCOUNT_OFS = 6'h0C;
    localparam logic [5:0] TCMP_OFS   = 6'h10;
    localparam logic [5:0] STAT_OFS   = 6'h14;

    localparam int TCTRL_EN      = 0;
    localparam int TCTRL_RELOAD  = 1;
    localparam int TCTRL_IRQ_EN  = 2;
    localparam int STAT_MATCH    = 0;
    localparam int STAT_MISALIGN = 1;

    localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

    function automatic logic [31:0] zext8(input logic [7:0] v);
        return {24'd0, v};
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_timer.sv
// Compare/match timer: control, counter, compare value, sticky match flag
// and the registered interrupt derived from them.
module mmio_timer
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tctrl_we,
    input  logic        tcount_we,
    input  logic        tcmp_we,
    input  logic        stat_we,
    input  logic [31:0] wdata,
    output logic [2:0]  tctrl,
    output logic [31:0] tcount,
    output logic [31:0] tcmp,
    output logic        match,
    output logic        timer_irq
);

    logic hit;

    assign hit = tctrl[TCTRL_EN] && (tcount == tcmp);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tctrl     <= 3'd0;
            tcount    <= 32'd0;
            tcmp      <= TCMP_RESET;
            match     <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            if (tctrl_we) tctrl <= wdata[2:0];
            if (tcmp_we)  tcmp  <= wdata;

            // A software write to the counter beats both reload and increment.
            if (tcount_we)
                tcount <= wdata;
            else if (tctrl[TCTRL_EN])
                tcount <= (hit && tctrl[TCTRL_RELOAD]) ? 32'd0 : tcount + 32'd1;

            // Hardware set wins over a same-cycle write-1-to-clear.
            if (hit)
                match <= 1'b1;
            else if (stat_we && wdata[STAT_MATCH])
                match <= 1'b0;

            timer_irq <= match & tctrl[TCTRL_IRQ_EN];
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-side memory responder: word RAM plus a 64-byte I/O page (LEDs,
// switches, timer, status). Loads are combinational; stores commit at the edge.
module dmem_mmio_responder
    import mmio_pkg::*;
#(
    parameter int          RAM_WORDS = 256,
    parameter logic [31:0] IO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    input  logic [7:0]  switches,
    output logic [7:0]  leds,
    output logic        timer_irq
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0] ram [RAM_WORDS];
    logic [7:0]  sw_meta, sw_sync;
    logic        misalign;

    logic        ram_sel, io_sel, aligned, wr_ok;
    logic [5:0]  io_ofs;
    logic        ram_we, led_we, tctrl_we, tcount_we, tcmp_we, stat_we;

    logic [2:0]  tctrl;
    logic [31:0] tcount, tcmp;
    logic        match;

    assign ram_sel = (memaddr < RAM_BYTES);
    assign io_sel  = (memaddr[31:6] == IO_BASE[31:6]);
    assign io_ofs  = {memaddr[5:2], 2'b00};
    assign aligned = (memaddr[1:0] == 2'b00);
    assign wr_ok   = memwrite && aligned;

    assign ram_we    = wr_ok && ram_sel;
    assign led_we    = wr_ok && io_sel && (io_ofs == LED_OFS);
    assign tctrl_we  = wr_ok && io_sel && (io_ofs == TCTRL_OFS);
    assign tcount_we = wr_ok && io_sel && (io_ofs == TCOUNT_OFS);
    assign tcmp_we   = wr_ok && io_sel && (io_ofs == TCMP_OFS);
    assign stat_we   = wr_ok && io_sel && (io_ofs == STAT_OFS);

    // RAM is not reset, but a store presented while reset is low is dropped.
    always_ff @(posedge clk) begin
        if (reset && ram_we)
            ram[memaddr[AW+1:2]] <= memwritedata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            leds     <= 8'd0;
            sw_meta  <= 8'd0;
            sw_sync  <= 8'd0;
            misalign <= 1'b0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
            if (led_we) leds <= memwritedata[7:0];
            if (memwrite && !aligned)
                misalign <= 1'b1;
            else if (stat_we && memwritedata[STAT_MISALIGN])
                misalign <= 1'b0;
        end
    end

    mmio_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .tctrl_we  (tctrl_we),
        .tcount_we (tcount_we),
        .tcmp_we   (tcmp_we),
        .stat_we   (stat_we),
        .wdata     (memwritedata),
        .tctrl     (tctrl),
        .tcount    (tcount),
        .tcmp      (tcmp),
        .match     (match),
        .timer_irq (timer_irq)
    );

    always_comb begin
        memreaddata = 32'd0;
        if (ram_sel) begin
            memreaddata = ram[memaddr[AW+1:2]];
        end else if (io_sel) begin
            case (io_ofs)
                LED_OFS:    memreaddata = zext8(leds);
                SW_OFS:     memreaddata = zext8(sw_sync);
                TCTRL_OFS:  memreaddata = {29'd0, tctrl};
                TCOUNT_OFS: memreaddata = tcount;
                TCMP_OFS:   memreaddata = tcmp;
                STAT_OFS:   memreaddata = {30'd0, misalign, match};
                default:    memreaddata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM store/load, timer match and
// reload, misalignment, switch sync, unmapped space and reset blocking.
module tb_dmem_mmio_responder;

    localparam logic [31:0] IO      = 32'hFFFF_0000;
    localparam logic [31:0] A_LED   = IO + 32'h00;
    localparam logic [31:0] A_SW    = IO + 32'h04;
    localparam logic [31:0] A_TCTRL = IO + 32'h08;
    localparam logic [31:0] A_TCNT  = IO + 32'h0C;
    localparam logic [31:0] A_TCMP  = IO + 32'h10;
    localparam logic [31:0] A_STAT  = IO + 32'h14;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] memaddr = 32'd0;
    logic [31:0] memwritedata = 32'd0;
    logic [31:0] memreaddata;
    logic [7:0]  switches = 8'd0;
    logic [7:0]  leds;
    logic        timer_irq;

    logic [31:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    dmem_mmio_responder #(.RAM_WORDS(256), .IO_BASE(32'hFFFF_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
        .memreaddata  (memreaddata),
        .switches     (switches),
        .leds         (leds),
        .timer_irq    (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] expv;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
            end
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        memwrite = 1'b0;
        memaddr  = a;
        exp_q.push_back(e);
        #2;
        check(tag, memreaddata);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memaddr      = a;
        memwritedata = d;
        memwrite     = 1'b1;
        tick(1);
        memwrite     = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] obs, input logic [31:0] e);
        exp_q.push_back(e);
        check(tag, obs);
    endtask

    initial begin
        // Reset
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        chk_out("rst_leds", {24'd0, leds}, 32'd0);
        chk_out("rst_irq", {31'd0, timer_irq}, 32'd0);
        rd("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
        rd("rst_tctrl", A_TCTRL, 32'd0);
        rd("rst_tcount", A_TCNT, 32'd0);
        rd("rst_stat", A_STAT, 32'd0);
        rd("rst_sw", A_SW, 32'd0);

        // RAM store/load and read-during-write
        wr(32'h10, 32'h1111_1111);
        memaddr = 32'h10; memwritedata = 32'hDEAD_BEEF; memwrite = 1'b1;
        exp_q.push_back(32'h1111_1111);
        #2;
        check("ram_rdw_old", memreaddata);
        tick(1);
        memwrite = 1'b0;
        rd("ram_load", 32'h10, 32'hDEAD_BEEF);

        // Timer match with irq
        wr(A_TCMP, 32'd5);
        wr(A_TCTRL, 32'b101);
        tick(6);
        rd("tm_stat_match", A_STAT, 32'h1);
        rd("tm_count6", A_TCNT, 32'd6);
        chk_out("tm_irq_lag", {31'd0, timer_irq}, 32'd0);
        tick(1);
        chk_out("tm_irq_rise", {31'd0, timer_irq}, 32'd1);
        rd("tm_count7", A_TCNT, 32'd7);
        wr(A_STAT, 32'h1);
        rd("tm_stat_clr", A_STAT, 32'h0);
        chk_out("tm_irq_hold", {31'd0, timer_irq}, 32'd1);
        rd("tm_count8", A_TCNT, 32'd8);
        tick(1);
        chk_out("tm_irq_fall", {31'd0, timer_irq}, 32'd0);
        rd("tm_count9", A_TCNT, 32'd9);

        // Auto-reload
        wr(A_TCTRL, 32'd0);
        wr(A_TCNT, 32'd0);
        wr(A_TCMP, 32'd3);
        wr(A_TCTRL, 32'b011);
        for (int i = 0; i < 8; i++) begin
            rd($sformatf("reload_cnt%0d", i), A_TCNT, 32'(i % 4));
            tick(1);
        end
        rd("reload_match", A_STAT, 32'h1);
        chk_out("reload_no_irq", {31'd0, timer_irq}, 32'd0);
        wr(A_TCTRL, 32'd0);
        wr(A_STAT, 32'h1);
        rd("reload_clr", A_STAT, 32'h0);

        // Misaligned stores
        wr(32'h12, 32'h1234_5678);
        rd("mis_ram_kept", 32'h10, 32'hDEAD_BEEF);
        rd("mis_lowbits_ignored", 32'h13, 32'hDEAD_BEEF);
        rd("mis_flag", A_STAT, 32'h2);
        wr(A_STAT + 32'd1, 32'h2);
        rd("mis_w1c_suppressed", A_STAT, 32'h2);
        wr(A_STAT, 32'h2);
        rd("mis_w1c", A_STAT, 32'h0);

        // Wrap and simultaneous count write
        wr(A_TCNT, 32'hFFFF_FFFF);
        wr(A_TCMP, 32'd0);
        wr(A_TCTRL, 32'b001);
        tick(1);
        rd("wrap_zero", A_TCNT, 32'd0);
        rd("wrap_nomatch", A_STAT, 32'h0);
        tick(1);
        rd("wrap_match", A_STAT, 32'h1);
        rd("wrap_count1", A_TCNT, 32'd1);
        wr(A_TCNT, 32'd7);
        rd("cnt_write_wins", A_TCNT, 32'd7);
        wr(A_TCTRL, 32'd0);
        wr(A_STAT, 32'h1);

        // Switch synchronizer
        switches = 8'hA5;
        tick(1);
        rd("sw_stage1", A_SW, 32'h0);
        tick(1);
        rd("sw_sync", A_SW, 32'hA5);

        // LEDs, unmapped space, unused offsets
        wr(A_LED, 32'h0000_013C);
        chk_out("led_out", {24'd0, leds}, 32'h3C);
        rd("led_read", A_LED, 32'h3C);
        rd("unmapped_rd", 32'h8000_0000, 32'd0);
        wr(32'h8000_0000, 32'hFFFF_FFFF);
        rd("unmapped_wr_ram", 32'h10, 32'hDEAD_BEEF);
        rd("unmapped_wr_led", A_LED, 32'h3C);
        wr(32'h3FC, 32'h0BAD_CAFE);
        rd("ram_top", 32'h3FC, 32'h0BAD_CAFE);
        rd("ram_past_end", 32'h400, 32'd0);
        rd("io_unused_ofs", IO + 32'h18, 32'd0);

        // Reset blocks stores
        wr(32'h20, 32'hCAFE_F00D);
        reset = 1'b0;
        wr(A_LED, 32'hFF);
        wr(32'h20, 32'd0);
        reset = 1'b1;
        chk_out("rst_blocks_led", {24'd0, leds}, 32'd0);
        rd("rst_blocks_ram", 32'h20, 32'hCAFE_F00D);
        rd("rst_tcmp_again", A_TCMP, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
